// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

    localparam int unsigned DEFAULT_DATA_W  = 32;
    localparam int unsigned DEFAULT_REG_NUM = 32;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_rdport.sv
// One read port: zero-register and INIT masking, plus write forwarding when
// REGFILE_MP_BYPASS_EN is defined.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned AW       = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic [AW-1:0]     rd_addr_i,
    input  logic [DATA_W-1:0] entry_i,
    input  logic              ready_i,
`ifdef REGFILE_MP_BYPASS_EN
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
`endif
    output logic [DATA_W-1:0] rd_data_c_o
);

    // Masking is applied last so it overrides any forwarded value.
    always_comb begin
        rd_data_c_o = entry_i;
`ifdef REGFILE_MP_BYPASS_EN
        if (wr_en_i && (rd_addr_i == wr_addr_i)) begin
            rd_data_c_o = wr_data_i;
        end
`endif
        if (!ready_i || ((ZERO_REG != 0) && (rd_addr_i == '0))) begin
            rd_data_c_o = '0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with a post-reset clearing sweep (INIT) before
// accepting writes (RUN). Optional write-to-read forwarding: REGFILE_MP_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter  int unsigned REG_NUM  = DEFAULT_REG_NUM,
    parameter  int unsigned RD_PORTS = 2,
    parameter  int unsigned ZERO_REG = 1,
    localparam int unsigned AW       = $clog2(REG_NUM)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wr_en,
    input  logic [AW-1:0]              i_addr_wr,
    input  logic [DATA_W-1:0]          i_data_wr,
    input  logic [RD_PORTS*AW-1:0]     i_addr_rd,
    output logic [RD_PORTS*DATA_W-1:0] o_data_rd,
    output logic                       o_ready,
    output logic                       o_wr_ack
);

    localparam logic [AW:0] INIT_LAST = (AW+1)'(REG_NUM - 1);

    state_e            state_q, state_d;
    logic [AW:0]       init_cnt_q, init_cnt_d;
    logic              ready_q, ready_d;
    logic              wr_ack_q, wr_ack_d;
    logic              mem_we_c;
    logic [AW-1:0]     mem_waddr_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic [DATA_W-1:0] mem_q [REG_NUM];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            ready_q    <= 1'b0;
            wr_ack_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            ready_q    <= ready_d;
            wr_ack_q   <= wr_ack_d;
        end
    end

    // INIT zeroes one entry per cycle; RUN commits host writes.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        ready_d     = 1'b0;
        wr_ack_d    = 1'b0;
        mem_we_c    = 1'b0;
        mem_waddr_c = init_cnt_q[AW-1:0];
        mem_wdata_c = '0;
        case (state_q)
            INIT: begin
                mem_we_c   = 1'b1;
                init_cnt_d = init_cnt_q + (AW+1)'(1);
                if (init_cnt_q == INIT_LAST) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end
            end
            RUN: begin
                ready_d = 1'b1;
                if (i_wr_en) begin
                    wr_ack_d    = 1'b1;
                    mem_waddr_c = i_addr_wr;
                    mem_wdata_c = i_data_wr;
                    mem_we_c    = !((ZERO_REG != 0) && (i_addr_wr == '0));
                end
            end
            default: state_d = INIT;
        endcase
        if (rst) begin
            mem_we_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[mem_waddr_c] <= mem_wdata_c;
        end
    end

    for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
        regfile_rdport #(
            .DATA_W   (DATA_W),
            .AW       (AW),
            .ZERO_REG (ZERO_REG)
        ) u_rdport (
            .rd_addr_i   (i_addr_rd[k*AW +: AW]),
            .entry_i     (mem_q[i_addr_rd[k*AW +: AW]]),
            .ready_i     (ready_q),
`ifdef REGFILE_MP_BYPASS_EN
            .wr_en_i     (i_wr_en),
            .wr_addr_i   (i_addr_wr),
            .wr_data_i   (i_data_wr),
`endif
            .rd_data_c_o (o_data_rd[k*DATA_W +: DATA_W])
        );
    end

    assign o_ready  = ready_q;
    assign o_wr_ack = wr_ack_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized self-checking bench for regfile_mp against a behavioural model,
// with directed literal checks of the reset/INIT/write/zero-register/bypass behaviour.
module tb_regfile_mp;

    localparam int unsigned DW  = 32;
    localparam int unsigned RN  = 32;
    localparam int unsigned RP  = 2;
    localparam int unsigned AW  = 5;

    logic             clk;
    logic             rst;
    logic             i_wr_en;
    logic [AW-1:0]    i_addr_wr;
    logic [DW-1:0]    i_data_wr;
    logic [RP*AW-1:0] i_addr_rd;
    logic [RP*DW-1:0] o_data_rd;
    logic             o_ready;
    logic             o_wr_ack;

    regfile_mp #(
        .DATA_W   (DW),
        .REG_NUM  (RN),
        .RD_PORTS (RP),
        .ZERO_REG (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (i_wr_en),
        .i_addr_wr (i_addr_wr),
        .i_data_wr (i_data_wr),
        .i_addr_rd (i_addr_rd),
        .o_data_rd (o_data_rd),
        .o_ready   (o_ready),
        .o_wr_ack  (o_wr_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: edges since reset, written contents, last-edge ack.
    int            m_cycles = 0;
    logic          m_valid  = 1'b0;
    logic          m_ack    = 1'b0;
    logic [DW-1:0] m_mem [RN];

    always @(posedge clk) begin
        if (rst) begin
            m_cycles <= 0;
            m_ack    <= 1'b0;
            m_valid  <= 1'b1;
            foreach (m_mem[j]) m_mem[j] <= '0;
        end else if (m_valid) begin
            m_ack <= (m_cycles >= RN) && i_wr_en;
            if ((m_cycles >= RN) && i_wr_en && (i_addr_wr != 0)) begin
                m_mem[i_addr_wr] <= i_data_wr;
            end
            if (m_cycles < 1000000) m_cycles <= m_cycles + 1;
        end
    end

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        if (m_cycles < RN) return '0;
        if (a == 0) return '0;
`ifdef REGFILE_MP_BYPASS_EN
        if (i_wr_en && (a == i_addr_wr)) return i_data_wr;
`endif
        return m_mem[a];
    endfunction

    // Compare process: every cycle, shortly after inputs settle.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (m_valid) begin
                check("m_ready", 64'(o_ready), 64'(m_cycles >= RN));
                check("m_ack", 64'(o_wr_ack), 64'(m_ack));
                for (int k = 0; k < RP; k++) begin
                    check("m_rd", 64'(o_data_rd[k*DW +: DW]),
                          64'(model_read(i_addr_rd[k*AW +: AW])));
                end
            end
        end
    end

    task automatic drive(input logic r, input logic we, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic [AW-1:0] r0,
                         input logic [AW-1:0] r1);
        @(negedge clk);
        rst       = r;
        i_wr_en   = we;
        i_addr_wr = wa;
        i_data_wr = wd;
        i_addr_rd = {r1, r0};
        #3;
    endtask

    // Runs with reset released in cycle 1; INIT must last exactly RN cycles.
    task automatic init_seq();
        for (int i = 1; i <= 33; i++) begin
            drive(1'b0, (i == 10), 5'd3, 32'h0000_00FF,
                  (i == 33) ? 5'd3 : AW'($urandom), (i == 33) ? 5'd9 : AW'($urandom));
            check("init_ready", 64'(o_ready), 64'(i == 33));
            check("init_ack", 64'(o_wr_ack), 64'd0);
            if (i < 33) begin
                check("init_rd0", 64'(o_data_rd[DW-1:0]), 64'd0);
                check("init_rd1", 64'(o_data_rd[2*DW-1:DW]), 64'd0);
            end else begin
                check("addr3_after_init", 64'(o_data_rd[DW-1:0]), 64'd0);
                check("addr9_after_init", 64'(o_data_rd[2*DW-1:DW]), 64'd0);
            end
        end
    endtask

    initial begin
        logic          r;
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] r0;
        logic [AW-1:0] r1;

        rst       = 1'b1;
        i_wr_en   = 1'b0;
        i_addr_wr = '0;
        i_data_wr = '0;
        i_addr_rd = '0;

        init_seq();

        // Plain write, both ports read the same entry.
        drive(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        check("ack_addr5", 64'(o_wr_ack), 64'd1);
        check("rd0_addr5", 64'(o_data_rd[DW-1:0]), 64'hDEAD_BEEF);
        check("rd1_addr5", 64'(o_data_rd[2*DW-1:DW]), 64'hDEAD_BEEF);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
        check("ack_pulse_end", 64'(o_wr_ack), 64'd0);

        // Writes to entry 0 are acknowledged but discarded.
        drive(1'b0, 1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        check("ack_addr0", 64'(o_wr_ack), 64'd1);
        check("rd_addr0", 64'(o_data_rd[DW-1:0]), 64'd0);

        // Same-cycle read and write of entry 7.
        drive(1'b0, 1'b1, 5'd7, 32'h1, 5'd0, 5'd0);
        drive(1'b0, 1'b1, 5'd7, 32'h2, 5'd7, 5'd7);
`ifdef REGFILE_MP_BYPASS_EN
        check("rw_same_addr7", 64'(o_data_rd[DW-1:0]), 64'h2);
`else
        check("rw_same_addr7", 64'(o_data_rd[DW-1:0]), 64'h1);
`endif
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
        check("addr7_after", 64'(o_data_rd[2*DW-1:DW]), 64'h2);

        // Reset mid-RUN: ready drops, INIT reruns, contents cleared.
        drive(1'b0, 1'b1, 5'd9, 32'hAA, 5'd0, 5'd0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
        check("addr9_before_rst", 64'(o_data_rd[DW-1:0]), 64'hAA);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
        init_seq();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 299) == 0);
            we = 1'($urandom_range(0, 1));
            wa = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom);
            wd = $urandom;
            r0 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
            r1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
            drive(r, we, wa, wd, r0, r1);
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning width of each entry in bits.
REQ-002 SHALL have parameter REG_NUM, default 32, meaning entry count (power of two, ≥2); AW = $clog2(REG_NUM).
REQ-003 SHALL have parameter RD_PORTS, default 2, meaning number of independent read ports (1..4).
REQ-004 SHALL have parameter ZERO_REG, default 1, meaning when 1, entry 0 is hardwired to zero.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-007 SHALL have port i_wr_en, input, 1, meaning write request.
REQ-008 SHALL have port i_addr_wr, input, AW, meaning write address.
REQ-009 SHALL have port i_data_wr, input, DATA_W, meaning write data.
REQ-010 SHALL have port i_addr_rd, input, RD_PORTS*AW, meaning packed read addresses, port k at bits [k*AW +: AW].
REQ-011 SHALL have port o_data_rd, output, RD_PORTS*DATA_W, meaning packed read data, port k at bits [k*DATA_W +: DATA_W].
REQ-012 SHALL have port o_ready, output, 1, meaning initialisation done; writes accepted and reads valid.
REQ-013 SHALL have port o_wr_ack, output, 1, meaning a write was committed on this edge (registered, one-cycle pulse).

Function
REQ-014 SHALL implement FSM states INIT and RUN; INIT clears one entry per cycle via counter init_cnt (AW+1 bits) from 0 up to REG_NUM-1.
REQ-015 SHALL transition INIT→RUN on the edge that clears entry REG_NUM-1; the INIT sequence lasts exactly REG_NUM cycles after rst deasserts.
REQ-016 SHALL drive o_ready=1 only in RUN.
REQ-017 SHALL ignore i_wr_en while in INIT; the write is dropped, not queued, and o_wr_ack stays 0.
REQ-018 SHALL, in RUN with i_wr_en=1, write i_data_wr to entry i_addr_wr at the rising edge and assert o_wr_ack for the next cycle.
REQ-019 SHALL, when ZERO_REG=1, discard writes to address 0 with o_wr_ack still asserted, and return 0 on any read of address 0.
REQ-020 SHALL provide combinational reads with zero latency; each port is independent, and all ports may address the same entry.
REQ-021 SHALL return 0 on all read ports while in INIT.
REQ-022 SHALL, for simultaneous read and write to the same address without bypass, return the old value (read-before-write).

Reset
REQ-023 SHALL, on rst=1 at an edge, enter INIT with init_cnt=0, o_ready=0 and o_wr_ack=0; this applies equally to reset mid-INIT or mid-RUN.
REQ-024 SHALL define no reset on the storage array itself; the INIT sweep provides zero contents.

Configuration
REQ-025 SHALL recognise the macro REGFILE_MP_BYPASS_EN.
REQ-026 SHALL, with REGFILE_MP_BYPASS_EN defined and in RUN, forward i_data_wr combinationally to any read port whose address equals i_addr_wr while i_wr_en=1 (write-before-read); the address-0 rule of REQ-019 takes priority.
REQ-027 SHALL, without the macro, behave as in REQ-022, with no forwarding logic synthesised.

Structure
REQ-028 SHALL place the FSM state enum (INIT, RUN) and the default DATA_W/REG_NUM constants in the shared package regfile_pkg.
REQ-029 SHALL use one sub-module, regfile_rdport, instantiated RD_PORTS times; it performs zero-register masking, INIT masking and optional bypass muxing per port.

Verification
REQ-030 SHALL verify: rst high 1 cycle, then low → o_ready=0 for exactly 32 cycles and 1 on cycle 33; all reads return 0 during this period.
REQ-031 SHALL verify: in RUN, write 0xDEADBEEF to addr 5 → o_wr_ack pulse next cycle; port0=5 and port1=5 both read 0xDEADBEEF.
REQ-032 SHALL verify: write 0x12345678 to addr 0 → o_wr_ack=1; read addr 0 returns 0x00000000.
REQ-033 SHALL verify: addr 7 holds 0x1; same-cycle write 0x2 to addr 7 with read of addr 7 → returns 0x2 with REGFILE_MP_BYPASS_EN defined, 0x1 without it; 0x2 thereafter in both builds.
REQ-034 SHALL verify: write during INIT at cycle 10 (addr 3, 0xFF) → no ack; addr 3 reads 0 after RUN is entered.
REQ-035 SHALL verify: rst asserted mid-RUN after addr 9 holds 0xAA → o_ready drops next cycle, 32-cycle INIT reruns, and addr 9 reads 0.
